datamover_cmd_controller: RTL and testbench

Sits between `sync_manager` and the AXI DataMover S2MM command/status ports. It buffers the unhandshaked command beats from `sync_manager`, retags them, and issues them to the DataMover under a bounded-outstanding limit. It also consumes S2MM status beats, checks them, and exposes drop/error statistics and an error interrupt to the PS register block.

---
 rtl/dm_cmd_pkg.sv | 31 +++
 rtl/cmd_fifo.sv | 57 +++++
 rtl/datamover_cmd_controller.sv | 127 ++++++++++++
 tb/tb_datamover_cmd_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_cmd_pkg.sv
// Shared definitions for the DataMover command controller: command and
// status field positions plus a saturating counter helper.
package dm_cmd_pkg;

  // Command word layout (fixed low 32 bits, address-relative upper fields)
  localparam int BTT_LO         = 0;
  localparam int BTT_W          = 23;
  localparam int TYPE_BIT       = 23;
  localparam int DSA_LO         = 24;
  localparam int EOF_BIT        = 30;
  localparam int DRR_BIT        = 31;
  localparam int ADDR_LO        = 32;
  // TAG sits at MM_ADDR_WIDTH + TAG_OFS
  localparam int TAG_OFS        = 32;
  localparam int TAG_W          = 4;
  // Bits the command word carries beyond the address
  localparam int CMD_EXTRA_BITS = 48;

  // S2MM status beat layout
  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;
  localparam int STS_TAG_LO = 0;

  // Increment that holds at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Single-clock FIFO with combinational head read and an occupancy counter.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH     = 80,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head,
  output logic [DEPTH_LOG:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int                 DEPTH     = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write
  // NOTE: the data array has no reset; occupancy guards every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/datamover_cmd_controller.sv
// Buffers sync_manager command beats, retags them, issues them to the AXI
// DataMover S2MM command port under an outstanding limit, and checks the
// returning status beats.
module datamover_cmd_controller
  import dm_cmd_pkg::*;
#(
  parameter  int MM_ADDR_WIDTH   = 32,
  parameter  int FIFO_DEPTH_LOG  = 2,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CMD_WIDTH       = MM_ADDR_WIDTH + CMD_EXTRA_BITS
) (
  input  logic                 SYS_aclk,
  input  logic                 SYS_areset,
  input  logic                 CTRL_enable,
  input  logic                 S_AXIS_tvalid,
  input  logic [CMD_WIDTH-1:0] S_AXIS_tdata,
  output logic                 M_AXIS_CMD_tvalid,
  input  logic                 M_AXIS_CMD_tready,
  output logic [CMD_WIDTH-1:0] M_AXIS_CMD_tdata,
  input  logic                 S_AXIS_STS_tvalid,
  output logic                 S_AXIS_STS_tready,
  input  logic [7:0]           S_AXIS_STS_tdata,
  output logic [3:0]           STAT_outstanding,
  output logic [15:0]          STAT_dropped,
  output logic [15:0]          STAT_errors,
  output logic                 STAT_busy,
  output logic                 IRQ_error
);

  localparam int         TAG_LO  = MM_ADDR_WIDTH + TAG_OFS;
  localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

  logic [TAG_W-1:0]        issue_tag;
  logic [TAG_W-1:0]        expect_tag;
  logic [CMD_WIDTH-1:0]    retagged;
  logic [FIFO_DEPTH_LOG:0] fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    capture;
  logic                    push_ok;
  logic                    drop;
  logic                    cmd_pop;
  logic                    sts_fire;
  logic                    sts_bad;
  logic                    sts_release;

  assign capture     = S_AXIS_tvalid & CTRL_enable;
  assign cmd_pop     = M_AXIS_CMD_tvalid & M_AXIS_CMD_tready;
  assign push_ok     = capture & (~fifo_full | cmd_pop);
  assign drop        = capture & fifo_full & ~cmd_pop;
  assign sts_fire    = S_AXIS_STS_tvalid & S_AXIS_STS_tready;
  assign sts_release = sts_fire & (STAT_outstanding != 4'd0);

  // The limit only drops on our own pop, so tvalid never falls without a handshake
  assign M_AXIS_CMD_tvalid = ~fifo_empty & (STAT_outstanding < OUT_MAX);
  assign STAT_busy         = (fifo_count != '0) | (STAT_outstanding != 4'd0);

  assign sts_bad = sts_fire &
                   (~S_AXIS_STS_tdata[STS_OKAY]   |
                     S_AXIS_STS_tdata[STS_SLVERR] |
                     S_AXIS_STS_tdata[STS_DECERR] |
                     S_AXIS_STS_tdata[STS_INTERR] |
                    (S_AXIS_STS_tdata[STS_TAG_LO +: TAG_W] != expect_tag) |
                    (STAT_outstanding == 4'd0));

  // Replace the incoming TAG field with the controller's own sequence number
  // NOTE: the whole word gets a default before the field overwrite, so no latch is inferred.
  always_comb begin
    retagged                    = S_AXIS_tdata;
    retagged[TAG_LO +: TAG_W]   = issue_tag;
  end

  cmd_fifo #(
    .WIDTH     (CMD_WIDTH),
    .DEPTH_LOG (FIFO_DEPTH_LOG)
  ) u_cmd_fifo (
    .clk       (SYS_aclk),
    .rst       (SYS_areset),
    .push      (push_ok),
    .push_data (retagged),
    .pop       (cmd_pop),
    .head      (M_AXIS_CMD_tdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue and expected-status tag sequences, both wrapping 15 -> 0
  always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
    if (SYS_areset) begin
      issue_tag  <= '0;
      expect_tag <= '0;
    end else begin
      if (push_ok)  issue_tag  <= issue_tag + 1'b1;
      if (sts_fire) expect_tag <= expect_tag + 1'b1;
    end
  end

  // Outstanding count: +1 per issue, -1 per status while nonzero
  always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
    if (SYS_areset) begin
      STAT_outstanding <= 4'd0;
    end else begin
      case ({cmd_pop, sts_release})
        2'b10:   STAT_outstanding <= STAT_outstanding + 4'd1;
        2'b01:   STAT_outstanding <= STAT_outstanding - 4'd1;
        default: STAT_outstanding <= STAT_outstanding;
      endcase
    end
  end

  // Saturating statistics, error pulse and status-ready flag
  always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
    if (SYS_areset) begin
      STAT_dropped      <= 16'd0;
      STAT_errors       <= 16'd0;
      IRQ_error         <= 1'b0;
      S_AXIS_STS_tready <= 1'b0;
    end else begin
      if (drop)    STAT_dropped <= sat_inc16(STAT_dropped);
      if (sts_bad) STAT_errors  <= sat_inc16(STAT_errors);
      IRQ_error         <= sts_bad;
      S_AXIS_STS_tready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_datamover_cmd_controller.sv
// Self-checking bench for datamover_cmd_controller: directed vector tables,
// a mid-operation reset sequence and randomized traffic against a
// queue-based reference model.
module tb_datamover_cmd_controller;

  localparam int A      = 32;
  localparam int CW     = A + 48;
  localparam int DEPTH  = 4;
  localparam int MAXO   = 2;
  localparam int TAG_LO = A + 32;

  logic          SYS_aclk = 1'b0;
  logic          SYS_areset;
  logic          CTRL_enable;
  logic          S_AXIS_tvalid;
  logic [CW-1:0] S_AXIS_tdata;
  logic          M_AXIS_CMD_tvalid;
  logic          M_AXIS_CMD_tready;
  logic [CW-1:0] M_AXIS_CMD_tdata;
  logic          S_AXIS_STS_tvalid;
  logic          S_AXIS_STS_tready;
  logic [7:0]    S_AXIS_STS_tdata;
  logic [3:0]    STAT_outstanding;
  logic [15:0]   STAT_dropped;
  logic [15:0]   STAT_errors;
  logic          STAT_busy;
  logic          IRQ_error;

  always #5 SYS_aclk = ~SYS_aclk;

  datamover_cmd_controller #(
    .MM_ADDR_WIDTH   (A),
    .FIFO_DEPTH_LOG  (2),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .SYS_aclk          (SYS_aclk),
    .SYS_areset        (SYS_areset),
    .CTRL_enable       (CTRL_enable),
    .S_AXIS_tvalid     (S_AXIS_tvalid),
    .S_AXIS_tdata      (S_AXIS_tdata),
    .M_AXIS_CMD_tvalid (M_AXIS_CMD_tvalid),
    .M_AXIS_CMD_tready (M_AXIS_CMD_tready),
    .M_AXIS_CMD_tdata  (M_AXIS_CMD_tdata),
    .S_AXIS_STS_tvalid (S_AXIS_STS_tvalid),
    .S_AXIS_STS_tready (S_AXIS_STS_tready),
    .S_AXIS_STS_tdata  (S_AXIS_STS_tdata),
    .STAT_outstanding  (STAT_outstanding),
    .STAT_dropped      (STAT_dropped),
    .STAT_errors       (STAT_errors),
    .STAT_busy         (STAT_busy),
    .IRQ_error         (IRQ_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CW-1:0] mq[$];
  int  m_out, m_itag, m_etag, m_drop, m_err;
  bit  m_irq, m_rdy;

  function automatic void model_reset();
    mq.delete();
    m_out = 0; m_itag = 0; m_etag = 0; m_drop = 0; m_err = 0;
    m_irq = 1'b0; m_rdy = 1'b0;
  endfunction

  function automatic bit m_tvalid();
    return (mq.size() > 0) && (m_out < MAXO);
  endfunction

  function automatic logic [CW-1:0] mk(input logic [31:0] addr);
    logic [CW-1:0] w;
    w = '0;
    w[CW-1:TAG_LO+4]  = 12'hABC;
    w[TAG_LO +: 4]    = 4'hF;
    w[32 +: A]        = addr;
    w[31:0]           = 32'h8040_0100;
    return w;
  endfunction

  task automatic check_post();
    check("outstanding", STAT_outstanding, m_out);
    check("dropped",     STAT_dropped,     m_drop);
    check("errors",      STAT_errors,      m_err);
    check("irq",         IRQ_error,        m_irq);
    check("busy",        STAT_busy,        (mq.size() != 0) || (m_out != 0));
    check("sts_tready",  S_AXIS_STS_tready, m_rdy);
  endtask

  // One clock: drive, check pre-edge command port, advance model, check post-edge stats
  task automatic run_cycle(input bit en, input bit sv, input logic [CW-1:0] data,
                           input bit rdy, input bit stv, input logic [7:0] std,
                           output bit pre_tv, output logic [3:0] pre_tag);
    bit pv, pop, fire, bad;
    logic [CW-1:0] w;
    CTRL_enable       = en;
    S_AXIS_tvalid     = sv;
    S_AXIS_tdata      = data;
    M_AXIS_CMD_tready = rdy;
    S_AXIS_STS_tvalid = stv;
    S_AXIS_STS_tdata  = std;
    #1;
    pre_tv  = M_AXIS_CMD_tvalid;
    pre_tag = M_AXIS_CMD_tdata[TAG_LO +: 4];
    pv = m_tvalid();
    check("cmd_tvalid", M_AXIS_CMD_tvalid, pv);
    if (pv) check("cmd_tdata", M_AXIS_CMD_tdata, mq[0]);
    pop  = pv && rdy;
    fire = stv && m_rdy;
    bad  = fire && (!std[7] || (std[6:4] != 3'b000) || (std[3:0] != m_etag[3:0]) || (m_out == 0));
    if (pop) void'(mq.pop_front());
    if (en && sv) begin
      if (mq.size() < DEPTH) begin
        w = data;
        w[TAG_LO +: 4] = m_itag[3:0];
        mq.push_back(w);
        m_itag = (m_itag + 1) % 16;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (fire && m_out > 0) m_out--;
    if (pop) m_out++;
    if (fire) m_etag = (m_etag + 1) % 16;
    if (bad && m_err < 65535) m_err++;
    m_irq = bad;
    m_rdy = 1'b1;
    @(posedge SYS_aclk);
    #1;
    check_post();
  endtask

  task automatic do_reset();
    SYS_areset        = 1'b1;
    CTRL_enable       = 1'b0;
    S_AXIS_tvalid     = 1'b0;
    S_AXIS_tdata      = '0;
    M_AXIS_CMD_tready = 1'b0;
    S_AXIS_STS_tvalid = 1'b0;
    S_AXIS_STS_tdata  = '0;
    repeat (2) @(posedge SYS_aclk);
    @(negedge SYS_aclk);
    SYS_areset = 1'b0;
    model_reset();
    @(posedge SYS_aclk);
    #1;
    m_rdy = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit en; bit sv; logic [31:0] addr; bit rdy; bit stv; logic [7:0] std;
    bit pv; int ptag; int o; int e; bit i; int d; bit b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit en, input bit sv, input logic [31:0] addr, input bit rdy,
                     input bit stv, input logic [7:0] std, input bit pv, input int ptag,
                     input int o, input int e, input bit i, input int d, input bit b);
    tbl.push_back('{en, sv, addr, rdy, stv, std, pv, ptag, o, e, i, d, b});
  endtask

  task automatic apply_table();
    bit tv;
    logic [3:0] tg;
    foreach (tbl[k]) begin
      run_cycle(tbl[k].en, tbl[k].sv, mk(tbl[k].addr), tbl[k].rdy, tbl[k].stv, tbl[k].std, tv, tg);
      check($sformatf("vec%0d tvalid", k), tv, tbl[k].pv);
      if (tbl[k].pv) check($sformatf("vec%0d tag", k), tg, tbl[k].ptag);
      check($sformatf("vec%0d outstanding", k), STAT_outstanding, tbl[k].o);
      check($sformatf("vec%0d errors", k),      STAT_errors,      tbl[k].e);
      check($sformatf("vec%0d irq", k),         IRQ_error,        tbl[k].i);
      check($sformatf("vec%0d dropped", k),     STAT_dropped,     tbl[k].d);
      check($sformatf("vec%0d busy", k),        STAT_busy,        tbl[k].b);
    end
    tbl.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit tv;
    logic [3:0] tg;
    logic [95:0] r;
    bit en, sv, rdy, stv;
    logic [7:0] std;

    do_reset();
    check_post();

    // Basic flow: three commands, outstanding limit, OKAY statuses
    add(1,1,32'h1000,1,0,8'h00, 0,0, 0,0,0,0,1);
    add(1,1,32'h2000,1,0,8'h00, 1,0, 1,0,0,0,1);
    add(1,1,32'h3000,1,0,8'h00, 1,1, 2,0,0,0,1);
    add(1,0,32'h0,   1,0,8'h00, 0,0, 2,0,0,0,1);
    add(1,0,32'h0,   1,1,8'h80, 0,0, 1,0,0,0,1);
    add(1,0,32'h0,   1,0,8'h00, 1,2, 2,0,0,0,1);
    add(1,0,32'h0,   1,1,8'h81, 0,0, 1,0,0,0,1);
    add(1,0,32'h0,   1,1,8'h82, 0,0, 0,0,0,0,0);
    add(1,0,32'h0,   1,0,8'h00, 0,0, 0,0,0,0,0);
    apply_table();

    // Reset with a command presented on the port and one outstanding
    run_cycle(1,1,mk(32'hB000),1,0,8'h00, tv, tg);
    run_cycle(1,1,mk(32'hB100),1,0,8'h00, tv, tg);
    CTRL_enable = 1'b0; S_AXIS_tvalid = 1'b0; M_AXIS_CMD_tready = 1'b0;
    #1;
    check("pre-reset tvalid", M_AXIS_CMD_tvalid, m_tvalid());
    check("pre-reset outstanding", STAT_outstanding, m_out);
    SYS_areset = 1'b1;
    #1;
    check("rst tvalid",      M_AXIS_CMD_tvalid, 1'b0);
    check("rst sts_tready",  S_AXIS_STS_tready, 1'b0);
    check("rst outstanding", STAT_outstanding,  4'd0);
    check("rst dropped",     STAT_dropped,      16'd0);
    check("rst errors",      STAT_errors,       16'd0);
    check("rst busy",        STAT_busy,         1'b0);
    check("rst irq",         IRQ_error,         1'b0);
    @(negedge SYS_aclk);
    SYS_areset = 1'b0;
    model_reset();
    @(posedge SYS_aclk);
    #1;
    m_rdy = 1'b1;
    check_post();
    run_cycle(1,1,mk(32'hC000),1,0,8'h00, tv, tg);
    run_cycle(1,0,mk(32'h0),   1,0,8'h00, tv, tg);
    check("post-reset first tag", tg, 4'd0);

    // Error status, spurious status, enable/drain, overflow and release
    do_reset();
    add(1,1,32'h4000,1,0,8'h00, 0,0, 0,0,0,0,1);
    add(1,1,32'h5000,1,0,8'h00, 1,0, 1,0,0,0,1);
    add(1,0,32'h0,   1,0,8'h00, 1,1, 2,0,0,0,1);
    add(1,0,32'h0,   1,1,8'h40, 0,0, 1,1,1,0,1);
    add(1,0,32'h0,   1,0,8'h00, 0,0, 1,1,0,0,1);
    add(1,0,32'h0,   1,1,8'h85, 0,0, 0,2,1,0,0);
    add(1,0,32'h0,   1,0,8'h00, 0,0, 0,2,0,0,0);
    add(1,0,32'h0,   1,1,8'h82, 0,0, 0,3,1,0,0);
    add(1,0,32'h0,   1,0,8'h00, 0,0, 0,3,0,0,0);
    add(1,1,32'h6000,0,0,8'h00, 0,0, 0,3,0,0,1);
    add(1,1,32'h7000,0,0,8'h00, 1,2, 0,3,0,0,1);
    add(0,1,32'h8000,0,0,8'h00, 1,2, 0,3,0,0,1);
    add(0,1,32'h9000,1,0,8'h00, 1,2, 1,3,0,0,1);
    add(0,0,32'h0,   1,0,8'h00, 1,3, 2,3,0,0,1);
    add(0,0,32'h0,   1,1,8'h83, 0,0, 1,3,0,0,1);
    add(0,0,32'h0,   1,1,8'h84, 0,0, 0,3,0,0,0);
    add(1,1,32'hA000,0,0,8'h00, 0,0, 0,3,0,0,1);
    add(1,1,32'hA100,0,0,8'h00, 1,4, 0,3,0,0,1);
    add(1,1,32'hA200,0,0,8'h00, 1,4, 0,3,0,0,1);
    add(1,1,32'hA300,0,0,8'h00, 1,4, 0,3,0,0,1);
    add(1,1,32'hA400,0,0,8'h00, 1,4, 0,3,0,1,1);
    add(1,1,32'hA500,0,0,8'h00, 1,4, 0,3,0,2,1);
    add(1,0,32'h0,   1,0,8'h00, 1,4, 1,3,0,2,1);
    add(1,0,32'h0,   1,0,8'h00, 1,5, 2,3,0,2,1);
    add(1,0,32'h0,   1,1,8'h85, 0,0, 1,3,0,2,1);
    add(1,0,32'h0,   1,1,8'h86, 1,6, 1,3,0,2,1);
    add(1,0,32'h0,   1,0,8'h00, 1,7, 2,3,0,2,1);
    add(1,0,32'h0,   1,1,8'h87, 0,0, 1,3,0,2,1);
    add(1,0,32'h0,   1,1,8'h88, 0,0, 0,3,0,2,0);
    apply_table();

    // Randomized traffic against the model, alternating light and heavy back-pressure
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      r   = {$urandom, $urandom, $urandom};
      en  = ($urandom % 8) != 0;
      sv  = ($urandom % 3) == 0;
      rdy = ((k / 500) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 5) == 0);
      stv = (m_out > 0) ? (($urandom % 3) == 0) : (($urandom % 25) == 0);
      if (($urandom % 6) == 0) std = 8'($urandom);
      else                     std = {4'b1000, m_etag[3:0]};
      run_cycle(en, sv, r[CW-1:0], rdy, stv, std, tv, tg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
